uart_fifo_wm: RTL and testbench
===============================

// Module: uart_fifo_wm
// PURPOSE
//  Parametrised UART FIFO with bus-side edge-qualified write, watermark and flush.
//  Successor to the fixed 9x16 TX FIFO. Serves as the TX or RX buffer between
//  the bus slave and the UART serialiser.
//  Adds: generic width/depth, occupancy count, programmable watermark, flush,
//  and a selectable read mode (level strobe or bus edge).
// PARAMETERS
//  WIDTH      9   data word width in bits
//  DEPTH_LOG2 4   log2 of FIFO depth; depth = 2**DEPTH_LOG2 (16)
//  WR_ADDR    0   bus Address value that qualifies Write
//  RD_ADDR    0   bus Address value that qualifies Read when READ_EDGE=1
//  READ_EDGE  0   0: Read is a 1-cycle strobe from the serialiser; 1: Read is bus-side, edge-qualified
// PORTS
//  Clock     in   1             system clock; all logic is on its rising edge
//  Reset     in   1             synchronous, active-high reset
//  ChipSelect in  1             bus chip select
//  Address   in   2             bus register address
//  Write     in   1             bus write; may be held high for several cycles
//  Read      in   1             pop request (meaning depends on READ_EDGE)
//  ClearOV   in   1             clears the sticky OV flag
//  Flush     in   1             empties the FIFO in one cycle
//  DataIn    in   WIDTH         write data
//  Threshold in   DEPTH_LOG2+1  watermark level
//  DataOut   out  WIDTH         head word (first-word fall-through)
//  Full      out  1             Level == 2**DEPTH_LOG2
//  Empty     out  1             Level == 0
//  OV        out  1             sticky overflow flag
//  AboveWm   out  1             Level >= Threshold
//  Level     out  DEPTH_LOG2+1  number of stored words
//  ReadPtr   out  DEPTH_LOG2    read index
//  WritePtr  out  DEPTH_LOG2    write index
// BEHAVIOUR
//  Reset values: pointers=0, Level=0, Empty=1, Full=0, OV=0, edge registers=0.
//    DataOut is don't-care while Empty.
//  Write qualification:
//    wq = Write & ChipSelect & (Address==WR_ADDR).
//    A push occurs only in the cycle where wq=1 and wq was 0 in the previous cycle.
//    Exactly one push per bus access, regardless of how long wq is held.
//  Read qualification:
//    READ_EDGE=0: a pop occurs in each cycle with Read=1.
//    READ_EDGE=1: same edge rule as write, using RD_ADDR.
//  Push: mem[WritePtr]<=DataIn; WritePtr+1 modulo depth (wraps 15->0 at defaults).
//  Pop: ReadPtr+1 modulo depth. DataOut=mem[ReadPtr] combinationally,
//    so the next word is valid in the cycle after the pop.
//  Level +1 on push only, -1 on pop only, unchanged on push+pop.
//    Flags are derived from Level; all register updates take effect the cycle after the event.
//  Push while Full and no pop: data dropped, pointers unchanged, OV<=1.
//  Push+pop while Full: both performed, Level stays at depth, no OV.
//  Pop while Empty: ignored; no pointer change, no error.
//  Push+pop while Empty: push only; the read is ignored.
//  ClearOV=1: OV<=0. An overflow in the same cycle wins (OV stays 1).
//  Flush=1: pointers<=0, Level<=0. OV is kept. Any push/pop in that cycle is discarded.
//    The edge registers still update, so a held Write does not re-push after Flush.
//  Threshold=0 makes AboveWm always 1.
//    Threshold > depth makes AboveWm always 0.
//  Reset asserted mid-access clears everything.
//    A Write still held after Reset deasserts counts as a fresh edge and pushes once.
// TESTING
//  Reset, then 16 single-cycle pushes 0x100..0x10F -> Full=1, Level=16, OV=0, WritePtr=0 (wrapped).
//  Write held 5 cycles with DataIn=0x0AA from empty -> Level=1, DataOut=0x0AA.
//  17th push when full -> OV=1, Level=16; ClearOV -> OV=0; pop sequence returns 0x100..0x10F in order.
//  Full plus simultaneous push and pop -> Level=16, OV=0; Empty plus pop -> Level=0, ReadPtr unchanged.
//  Threshold=4: three pushes -> AboveWm=0; fourth push -> AboveWm=1; Flush -> Level=0, Empty=1, OV unchanged.
//  READ_EDGE=1: Read held 3 cycles at RD_ADDR with ChipSelect=1 -> exactly one pop; wrong Address -> no pop.

Source files
------------

// File: rtl/uart_fifo_wm.sv
// rtl/uart_fifo_wm.sv - parametrised UART FIFO with edge-qualified bus write, watermark and flush
module uart_fifo_wm #(
  parameter int WIDTH      = 9,
  parameter int DEPTH_LOG2 = 4,
  parameter int WR_ADDR    = 0,
  parameter int RD_ADDR    = 0,
  parameter int READ_EDGE  = 0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  ChipSelect,
  input  logic [1:0]            Address,
  input  logic                  Write,
  input  logic                  Read,
  input  logic                  ClearOV,
  input  logic                  Flush,
  input  logic [WIDTH-1:0]      DataIn,
  input  logic [DEPTH_LOG2:0]   Threshold,
  output logic [WIDTH-1:0]      DataOut,
  output logic                  Full,
  output logic                  Empty,
  output logic                  OV,
  output logic                  AboveWm,
  output logic [DEPTH_LOG2:0]   Level,
  output logic [DEPTH_LOG2-1:0] ReadPtr,
  output logic [DEPTH_LOG2-1:0] WritePtr
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_LVL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic wq, wq_d, rq, rq_d;
  logic push_req, pop_req;
  logic do_push, do_pop, overflow;

  // Bus accesses may hold Write/Read for several cycles; only the rising edge counts.
  assign wq       = Write & ChipSelect & (Address == 2'(WR_ADDR));
  assign rq       = Read & ChipSelect & (Address == 2'(RD_ADDR));
  assign push_req = wq & ~wq_d;
  assign pop_req  = (READ_EDGE != 0) ? (rq & ~rq_d) : Read;

  assign Empty   = (Level == '0);
  assign Full    = (Level == DEPTH_LVL);
  assign AboveWm = (Level >= Threshold);
  assign DataOut = mem[ReadPtr];

  // A pop frees a slot in the same cycle, so push+pop while full is legal.
  assign do_pop   = pop_req & ~Empty & ~Flush;
  assign do_push  = push_req & (~Full | do_pop) & ~Flush;
  assign overflow = push_req & Full & ~do_pop & ~Flush;

  always_ff @(posedge Clock) begin
    if (do_push) begin
      mem[WritePtr] <= DataIn;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      ReadPtr  <= '0;
      WritePtr <= '0;
      Level    <= '0;
      OV       <= 1'b0;
      wq_d     <= 1'b0;
      rq_d     <= 1'b0;
    end else begin
      wq_d <= wq;
      rq_d <= rq;
      if (overflow) begin
        OV <= 1'b1;
      end else if (ClearOV) begin
        OV <= 1'b0;
      end
      if (Flush) begin
        ReadPtr  <= '0;
        WritePtr <= '0;
        Level    <= '0;
      end else begin
        if (do_push) begin
          WritePtr <= WritePtr + DEPTH_LOG2'(1);
        end
        if (do_pop) begin
          ReadPtr <= ReadPtr + DEPTH_LOG2'(1);
        end
        case ({do_push, do_pop})
          2'b10:   Level <= Level + (DEPTH_LOG2 + 1)'(1);
          2'b01:   Level <= Level - (DEPTH_LOG2 + 1)'(1);
          default: Level <= Level;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_fifo_wm.sv
// tb/tb_uart_fifo_wm.sv - scoreboard bench for uart_fifo_wm, strobe-read and edge-read instances
module tb_uart_fifo_wm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [8:0] qa[$];
  logic [8:0] qb[$];

  // Instance A: READ_EDGE=0 (serialiser strobe)
  logic       a_rst, a_cs, a_write, a_read, a_clrov, a_flush;
  logic [1:0] a_addr;
  logic [8:0] a_din, a_dout;
  logic [4:0] a_thr, a_level;
  logic [3:0] a_rptr, a_wptr;
  logic       a_full, a_empty, a_ov, a_wm;

  // Instance B: READ_EDGE=1, reads at address 1
  logic       b_rst, b_cs, b_write, b_read, b_clrov, b_flush;
  logic [1:0] b_addr;
  logic [8:0] b_din, b_dout;
  logic [4:0] b_thr, b_level;
  logic [3:0] b_rptr, b_wptr;
  logic       b_full, b_empty, b_ov, b_wm;

  uart_fifo_wm #(.WIDTH(9), .DEPTH_LOG2(4), .WR_ADDR(0), .RD_ADDR(0), .READ_EDGE(0)) dut_a (
    .Clock(clk), .Reset(a_rst), .ChipSelect(a_cs), .Address(a_addr), .Write(a_write),
    .Read(a_read), .ClearOV(a_clrov), .Flush(a_flush), .DataIn(a_din), .Threshold(a_thr),
    .DataOut(a_dout), .Full(a_full), .Empty(a_empty), .OV(a_ov), .AboveWm(a_wm),
    .Level(a_level), .ReadPtr(a_rptr), .WritePtr(a_wptr)
  );

  uart_fifo_wm #(.WIDTH(9), .DEPTH_LOG2(4), .WR_ADDR(0), .RD_ADDR(1), .READ_EDGE(1)) dut_b (
    .Clock(clk), .Reset(b_rst), .ChipSelect(b_cs), .Address(b_addr), .Write(b_write),
    .Read(b_read), .ClearOV(b_clrov), .Flush(b_flush), .DataIn(b_din), .Threshold(b_thr),
    .DataOut(b_dout), .Full(b_full), .Empty(b_empty), .OV(b_ov), .AboveWm(b_wm),
    .Level(b_level), .ReadPtr(b_rptr), .WritePtr(b_wptr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [8:0] d, input bit expect_store);
    a_write = 1'b1;
    a_din = d;
    step();
    a_write = 1'b0;
    step();
    if (expect_store) qa.push_back(d);
  endtask

  task automatic pop_a();
    logic [8:0] exp;
    if (qa.size() == 0) begin
      check("pop_a_underflow", 32'd1, 32'd0);
    end else begin
      exp = qa.pop_front();
      check("pop_a_data", 32'(a_dout), 32'(exp));
    end
    a_read = 1'b1;
    step();
    a_read = 1'b0;
  endtask

  task automatic push_b(input logic [8:0] d);
    b_addr = 2'd0;
    b_write = 1'b1;
    b_din = d;
    step();
    b_write = 1'b0;
    step();
    qb.push_back(d);
  endtask

  initial begin
    logic [3:0] rptr_snap;
    a_rst = 1'b1; a_cs = 1'b1; a_addr = 2'd0; a_write = 1'b0; a_read = 1'b0;
    a_clrov = 1'b0; a_flush = 1'b0; a_din = '0; a_thr = 5'd4;
    b_rst = 1'b1; b_cs = 1'b1; b_addr = 2'd0; b_write = 1'b0; b_read = 1'b0;
    b_clrov = 1'b0; b_flush = 1'b0; b_din = '0; b_thr = 5'd4;
    step();
    step();
    check("rst_level", 32'(a_level), 32'd0);
    check("rst_empty", 32'(a_empty), 32'd1);
    check("rst_full", 32'(a_full), 32'd0);
    check("rst_ov", 32'(a_ov), 32'd0);
    check("rst_rptr", 32'(a_rptr), 32'd0);
    check("rst_wptr", 32'(a_wptr), 32'd0);
    a_rst = 1'b0;
    b_rst = 1'b0;
    step();

    for (int i = 0; i < 16; i++) push_a(9'h100 + 9'(i), 1'b1);
    check("fill_full", 32'(a_full), 32'd1);
    check("fill_level", 32'(a_level), 32'd16);
    check("fill_ov", 32'(a_ov), 32'd0);
    check("fill_wptr_wrap", 32'(a_wptr), 32'd0);

    push_a(9'h1FF, 1'b0);
    check("ovf_ov", 32'(a_ov), 32'd1);
    check("ovf_level", 32'(a_level), 32'd16);
    a_clrov = 1'b1;
    step();
    a_clrov = 1'b0;
    check("clrov_ov", 32'(a_ov), 32'd0);

    check("full_pushpop_head", 32'(a_dout), 32'(qa.pop_front()));
    qa.push_back(9'h1AB);
    a_write = 1'b1; a_read = 1'b1; a_din = 9'h1AB;
    step();
    a_write = 1'b0; a_read = 1'b0;
    step();
    check("full_pushpop_level", 32'(a_level), 32'd16);
    check("full_pushpop_ov", 32'(a_ov), 32'd0);

    while (qa.size() > 0) pop_a();
    check("drain_level", 32'(a_level), 32'd0);
    check("drain_empty", 32'(a_empty), 32'd1);

    rptr_snap = a_rptr;
    a_read = 1'b1;
    step();
    a_read = 1'b0;
    check("empty_pop_level", 32'(a_level), 32'd0);
    check("empty_pop_rptr", 32'(a_rptr), 32'(rptr_snap));

    a_write = 1'b1; a_read = 1'b1; a_din = 9'h033;
    step();
    a_write = 1'b0; a_read = 1'b0;
    qa.push_back(9'h033);
    check("empty_pushpop_level", 32'(a_level), 32'd1);
    pop_a();

    a_write = 1'b1; a_din = 9'h0AA;
    repeat (5) step();
    a_write = 1'b0;
    step();
    qa.push_back(9'h0AA);
    check("held_write_level", 32'(a_level), 32'd1);
    check("held_write_dout", 32'(a_dout), 32'h0AA);
    pop_a();

    a_thr = 5'd4;
    for (int i = 0; i < 3; i++) push_a(9'h040 + 9'(i), 1'b1);
    check("wm_three", 32'(a_wm), 32'd0);
    push_a(9'h043, 1'b1);
    check("wm_four", 32'(a_wm), 32'd1);
    a_thr = 5'd0;
    #1 check("wm_thr0", 32'(a_wm), 32'd1);
    a_thr = 5'd17;
    #1 check("wm_thr17", 32'(a_wm), 32'd0);
    a_thr = 5'd4;
    a_write = 1'b1; a_flush = 1'b1; a_din = 9'h077;
    step();
    a_flush = 1'b0;
    step();
    a_write = 1'b0;
    step();
    qa.delete();
    check("flush_level", 32'(a_level), 32'd0);
    check("flush_empty", 32'(a_empty), 32'd1);
    check("flush_ov", 32'(a_ov), 32'd0);
    check("flush_ptrs", 32'({a_rptr, a_wptr}), 32'd0);

    a_write = 1'b1; a_din = 9'h055;
    step();
    check("rst_mid_pre", 32'(a_level), 32'd1);
    a_rst = 1'b1;
    step();
    check("rst_mid_level", 32'(a_level), 32'd0);
    a_rst = 1'b0;
    step();
    check("rst_mid_repush", 32'(a_level), 32'd1);
    step();
    check("rst_mid_once", 32'(a_level), 32'd1);
    a_write = 1'b0;
    step();
    check("rst_mid_dout", 32'(a_dout), 32'h055);

    push_b(9'h011);
    push_b(9'h022);
    check("b_level2", 32'(b_level), 32'd2);
    b_addr = 2'd1; b_read = 1'b1;
    repeat (3) step();
    b_read = 1'b0;
    step();
    void'(qb.pop_front());
    check("b_edge_read_level", 32'(b_level), 32'd1);
    check("b_edge_read_dout", 32'(b_dout), 32'(qb[0]));
    b_addr = 2'd2; b_read = 1'b1;
    repeat (2) step();
    b_read = 1'b0;
    step();
    check("b_wrong_addr_level", 32'(b_level), 32'd1);
    b_addr = 2'd1; b_cs = 1'b0; b_read = 1'b1;
    repeat (2) step();
    b_read = 1'b0; b_cs = 1'b1;
    step();
    check("b_no_cs_level", 32'(b_level), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
